// File: rtl/uart_frame_ctrl.sv
// Frame parser behind uart_rx: SYNC, ADDR, DATA, CHK frames write one byte into
// a display register bank, with inter-byte timeout and a saturating error count.
module uart_frame_ctrl #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
    parameter int unsigned TIMEOUT_CLKS = 4096
) (
    input  logic                    i_Clock,
    input  logic                    i_Reset,
    input  logic                    i_Rx_DV,
    input  logic [7:0]              i_Rx_Byte,
    output logic [8*NUM_DIGITS-1:0] o_Digits,
    output logic                    o_Frame_Ok,
    output logic                    o_Frame_Err,
    output logic [7:0]              o_Err_Count,
    output logic                    o_Busy
);

    localparam int unsigned CW = (TIMEOUT_CLKS > 2) ? $clog2(TIMEOUT_CLKS) : 1;
    localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CLKS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA,
        S_CHK
    } state_t;

    state_t                  state;
    logic [CW-1:0]           tmo_cnt;
    logic [7:0]              addr_q;
    logic [7:0]              data_q;
    logic [8*NUM_DIGITS-1:0] digits_q;
    logic                    frame_ok_q;
    logic                    frame_err_q;
    logic [7:0]              err_count_q;
    logic                    busy_q;
    logic                    tmo_hit;

    // A byte arriving on the last allowed cycle wins over the timeout.
    assign tmo_hit = (state != S_IDLE) && !i_Rx_DV && (tmo_cnt == TMO_LAST);

    always_ff @(posedge i_Clock) begin
        if (i_Reset) begin
            state       <= S_IDLE;
            tmo_cnt     <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            digits_q    <= '0;
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;
            err_count_q <= '0;
            busy_q      <= 1'b0;
        end else begin
            frame_ok_q  <= 1'b0;
            frame_err_q <= 1'b0;

            if (i_Rx_DV || state == S_IDLE)
                tmo_cnt <= '0;
            else
                tmo_cnt <= tmo_cnt + CW'(1);

            if (tmo_hit) begin
                state       <= S_IDLE;
                busy_q      <= 1'b0;
                frame_err_q <= 1'b1;
                if (err_count_q != 8'hFF)
                    err_count_q <= err_count_q + 8'd1;
            end else if (i_Rx_DV) begin
                case (state)
                    S_IDLE: begin
                        if (i_Rx_Byte == SYNC_BYTE) begin
                            state  <= S_ADDR;
                            busy_q <= 1'b1;
                        end
                    end
                    S_ADDR: begin
                        addr_q <= i_Rx_Byte;
                        state  <= S_DATA;
                    end
                    S_DATA: begin
                        data_q <= i_Rx_Byte;
                        state  <= S_CHK;
                    end
                    S_CHK: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                        if (i_Rx_Byte == (addr_q ^ data_q) && 32'(addr_q) < NUM_DIGITS) begin
                            frame_ok_q <= 1'b1;
                            for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
                                if (32'(addr_q) == k)
                                    digits_q[8*k +: 8] <= data_q;
                            end
                        end else begin
                            frame_err_q <= 1'b1;
                            if (err_count_q != 8'hFF)
                                err_count_q <= err_count_q + 8'd1;
                        end
                    end
                    default: begin
                        state  <= S_IDLE;
                        busy_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_Digits    = digits_q;
    assign o_Frame_Ok  = frame_ok_q;
    assign o_Frame_Err = frame_err_q;
    assign o_Err_Count = err_count_q;
    assign o_Busy      = busy_q;

endmodule
